// File: rtl/arm_core_pkg.sv
// Shared definitions for the ARM core register-file read side.
// Holds the PC register number, default widths and the operand-fetch state encoding.
package arm_core_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_REGFILE_WIDTH = 4;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_READ = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking in-flight destination writes.
// Answers whether any used source of the offered instruction is still pending.
module regfile_scoreboard
  import arm_core_pkg::*;
#(
  parameter int RW = DEF_REGFILE_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_setEn,
  input  logic [RW-1:0] i_setAddr,
  input  logic          i_clrEn,
  input  logic [RW-1:0] i_clrAddr,
  input  logic [3*RW-1:0] i_qSrc,
  input  logic [2:0]    i_qUse,
  output logic          o_hazard
);

  localparam int NREG = 1 << RW;
  localparam logic [RW-1:0] PC_ADDR = RW'(REG_PC);

  logic [NREG-1:0] r_busy;

  // The set is applied after the clear so an issue on the retiring register stays busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
    end else if (i_flush) begin
      r_busy <= '0;
    end else begin
      if (i_clrEn && (i_clrAddr != PC_ADDR)) r_busy[i_clrAddr] <= 1'b0;
      if (i_setEn && (i_setAddr != PC_ADDR)) r_busy[i_setAddr] <= 1'b1;
    end
  end

  always_comb begin
    logic [RW-1:0] w_src;
    o_hazard = 1'b0;
    w_src    = '0;
    for (int i = 0; i < 3; i++) begin
      w_src = i_qSrc[i*RW +: RW];
      if (i_qUse[i] && (w_src != PC_ADDR) && r_busy[w_src] &&
          !(i_clrEn && (i_clrAddr == w_src))) begin
        o_hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Register-file read master: issues RADD, captures RDAT with writeback bypass and PC substitution,
// and hands operands to execute over valid/ready while stalling decode on RAW hazards.
module regfile_operand_fetch
  import arm_core_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int REGFILE_WIDTH = DEF_REGFILE_WIDTH,
  parameter int TAG_WIDTH     = 32,
  parameter int PC_OFFSET     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dec_valid,
  output logic                       dec_ready,
  input  logic [3*REGFILE_WIDTH-1:0] dec_src,
  input  logic [2:0]                 dec_use,
  input  logic [REGFILE_WIDTH-1:0]   dec_rd,
  input  logic                       dec_wr,
  input  logic [DATA_WIDTH-1:0]      dec_pc,
  input  logic [TAG_WIDTH-1:0]       dec_tag,
  output logic [REGFILE_WIDTH-1:0]   rf_radd1,
  output logic [REGFILE_WIDTH-1:0]   rf_radd2,
  output logic [REGFILE_WIDTH-1:0]   rf_radd3,
  input  logic [DATA_WIDTH-1:0]      rf_rdat1,
  input  logic [DATA_WIDTH-1:0]      rf_rdat2,
  input  logic [DATA_WIDTH-1:0]      rf_rdat3,
  input  logic                       wb_en,
  input  logic [REGFILE_WIDTH-1:0]   wb_addr,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [DATA_WIDTH-1:0]      ex_op1,
  output logic [DATA_WIDTH-1:0]      ex_op2,
  output logic [DATA_WIDTH-1:0]      ex_op3,
  output logic [TAG_WIDTH-1:0]       ex_tag
);

  localparam int RW = REGFILE_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [RW-1:0] PC_ADDR = RW'(REG_PC);

  fetch_state_e r_state, w_nextState;
  logic          w_hazard, w_accept;
  logic [DW-1:0] r_pc;
  logic [2:0]    r_use;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [DW-1:0] w_op1, w_op2, w_op3;

  function automatic logic [DW-1:0] pickOperand(
    input logic useSrc, input logic [RW-1:0] src, input logic [DW-1:0] rdat,
    input logic [DW-1:0] pcVal, input logic wbEn, input logic [RW-1:0] wbAddr,
    input logic [DW-1:0] wbData);
    if (!useSrc)                      return '0;
    else if (src == PC_ADDR)          return pcVal + DW'(PC_OFFSET);
    else if (wbEn && wbAddr == src)   return wbData;
    else                              return rdat;
  endfunction

  assign w_op1 = pickOperand(r_use[0], rf_radd1, rf_rdat1, r_pc, wb_en, wb_addr, wb_data);
  assign w_op2 = pickOperand(r_use[1], rf_radd2, rf_rdat2, r_pc, wb_en, wb_addr, wb_data);
  assign w_op3 = pickOperand(r_use[2], rf_radd3, rf_rdat3, r_pc, wb_en, wb_addr, wb_data);

  regfile_scoreboard #(.RW(RW)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_setEn   (w_accept && dec_wr),
    .i_setAddr (dec_rd),
    .i_clrEn   (wb_en),
    .i_clrAddr (wb_addr),
    .i_qSrc    (dec_src),
    .i_qUse    (dec_use),
    .o_hazard  (w_hazard)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= FS_IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    dec_ready   = ((r_state == FS_IDLE) || ((r_state == FS_HOLD) && ex_ready)) &&
                  !w_hazard && !flush;
    w_accept    = dec_valid && dec_ready;
    case (r_state)
      FS_IDLE: if (w_accept) w_nextState = FS_READ;
      FS_READ: w_nextState = FS_HOLD;
      FS_HOLD: if (ex_ready) w_nextState = w_accept ? FS_READ : FS_IDLE;
      default: w_nextState = FS_IDLE;
    endcase
    if (flush) w_nextState = FS_IDLE;
  end

  // Operands are sampled one edge after issue, once the RegFile has had its negedge to read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid <= 1'b0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_op3   <= '0;
      ex_tag   <= '0;
      rf_radd1 <= '0;
      rf_radd2 <= '0;
      rf_radd3 <= '0;
      r_pc     <= '0;
      r_use    <= '0;
      r_tag    <= '0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (r_state == FS_READ) begin
        ex_valid <= 1'b1;
        ex_op1   <= w_op1;
        ex_op2   <= w_op2;
        ex_op3   <= w_op3;
        ex_tag   <= r_tag;
      end else if ((r_state == FS_HOLD) && ex_ready) begin
        ex_valid <= 1'b0;
      end
      if (w_accept) begin
        rf_radd1 <= dec_src[RW-1:0];
        rf_radd2 <= dec_src[2*RW-1:RW];
        rf_radd3 <= dec_src[3*RW-1:2*RW];
        r_pc     <= dec_pc;
        r_use    <= dec_use;
        r_tag    <= dec_tag;
      end
    end
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a small negedge-latching RegFile model.
module tb_regfile_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, flush, decValid, decReady, decWr, wbEn, exValid, exReady;
  logic [11:0] decSrc;
  logic [2:0]  decUse;
  logic [3:0]  decRd, wbAddr, radd1, radd2, radd3;
  logic [31:0] decPc, decTag, wbData, rdat1, rdat2, rdat3, exOp1, exOp2, exOp3, exTag;

  logic [31:0] mem [16] = '{0: 32'h55, 3: 32'h8, 4: 32'h10, 7: 32'h77, default: 32'h0};
  logic [3:0]  lat1 = '0, lat2 = '0, lat3 = '0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // RegFile model: addresses latched on negedge, writes land at posedge.
  always @(negedge clk) begin
    lat1 <= radd1;
    lat2 <= radd2;
    lat3 <= radd3;
  end
  always @(posedge clk) if (wbEn) mem[wbAddr] <= wbData;
  assign rdat1 = mem[lat1];
  assign rdat2 = mem[lat2];
  assign rdat3 = mem[lat3];

  regfile_operand_fetch dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(decValid), .dec_ready(decReady), .dec_src(decSrc), .dec_use(decUse),
    .dec_rd(decRd), .dec_wr(decWr), .dec_pc(decPc), .dec_tag(decTag),
    .rf_radd1(radd1), .rf_radd2(radd2), .rf_radd3(radd3),
    .rf_rdat1(rdat1), .rf_rdat2(rdat2), .rf_rdat3(rdat3),
    .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData),
    .ex_valid(exValid), .ex_ready(exReady),
    .ex_op1(exOp1), .ex_op2(exOp2), .ex_op3(exOp3), .ex_tag(exTag)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] rs, input logic [3:0] rm,
                               input logic [3:0] rn, input logic [2:0] useMask,
                               input logic [3:0] rd, input logic wr,
                               input logic [31:0] pc, input logic [31:0] tag);
    decValid = v;
    decSrc   = {rs, rm, rn};
    decUse   = useMask;
    decRd    = rd;
    decWr    = wr;
    decPc    = pc;
    decTag   = tag;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; exReady = 1'b0;
    wbEn = 1'b0; wbAddr = '0; wbData = '0;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 32'h0, 32'h0);

    $display("[TB] reset");
    cycle(); cycle();
    checkOutput("rst_valid", {31'b0, exValid}, 32'h0);
    checkOutput("rst_op1", exOp1, 32'h0);
    checkOutput("rst_tag", exTag, 32'h0);
    checkOutput("rst_radd1", {28'b0, radd1}, 32'h0);
    rst = 1'b1; #1;
    checkOutput("rst_ready", {31'b0, decReady}, 32'h1);

    $display("[TB] basic read r3/r4");
    applyStimulus(1'b1, 4'd0, 4'd4, 4'd3, 3'b011, 4'd0, 1'b0, 32'h0, 32'hA1); #1;
    checkOutput("t2_ready", {31'b0, decReady}, 32'h1);
    cycle(); decValid = 1'b0;
    checkOutput("t2_valid_read", {31'b0, exValid}, 32'h0);
    checkOutput("t2_radd1", {28'b0, radd1}, 32'h3);
    checkOutput("t2_radd2", {28'b0, radd2}, 32'h4);
    cycle();
    checkOutput("t2_valid", {31'b0, exValid}, 32'h1);
    checkOutput("t2_op1", exOp1, 32'h8);
    checkOutput("t2_op2", exOp2, 32'h10);
    checkOutput("t2_op3_unused", exOp3, 32'h0);
    checkOutput("t2_tag", exTag, 32'hA1);
    checkOutput("t2_hold_ready", {31'b0, decReady}, 32'h0);

    $display("[TB] stall in HOLD");
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("t5_valid", {31'b0, exValid}, 32'h1);
      checkOutput("t5_op1", exOp1, 32'h8);
      checkOutput("t5_op2", exOp2, 32'h10);
      checkOutput("t5_tag", exTag, 32'hA1);
      checkOutput("t5_ready", {31'b0, decReady}, 32'h0);
    end

    $display("[TB] back-to-back issue, r15 source");
    exReady = 1'b1;
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd15, 3'b001, 4'd15, 1'b1, 32'h100, 32'hB2); #1;
    checkOutput("t4_ready", {31'b0, decReady}, 32'h1);
    cycle(); decValid = 1'b0; exReady = 1'b0;
    checkOutput("t4_valid_read", {31'b0, exValid}, 32'h0);
    cycle();
    checkOutput("t4_valid", {31'b0, exValid}, 32'h1);
    checkOutput("t4_op1_pc", exOp1, 32'h108);
    checkOutput("t4_op2", exOp2, 32'h0);
    checkOutput("t4_tag", exTag, 32'hB2);
    exReady = 1'b1;
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd15, 3'b001, 4'd5, 1'b1, 32'h200, 32'hC3); #1;
    checkOutput("t4_r15_ready", {31'b0, decReady}, 32'h1);

    $display("[TB] RAW hazard on r5");
    cycle(); exReady = 1'b0;
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd5, 3'b001, 4'd0, 1'b0, 32'h0, 32'hD4);
    cycle();
    checkOutput("t3_c3_valid", {31'b0, exValid}, 32'h1);
    checkOutput("t3_c3_op1", exOp1, 32'h208);
    checkOutput("t3_c3_tag", exTag, 32'hC3);
    exReady = 1'b1; #1;
    checkOutput("t3_stall_hold", {31'b0, decReady}, 32'h0);
    cycle();
    checkOutput("t3_idle_valid", {31'b0, exValid}, 32'h0);
    checkOutput("t3_stall_idle", {31'b0, decReady}, 32'h0);
    cycle();
    checkOutput("t3_stall_idle2", {31'b0, decReady}, 32'h0);
    wbEn = 1'b1; wbAddr = 4'd5; wbData = 32'hDEAD; #1;
    checkOutput("t3_wb_ready", {31'b0, decReady}, 32'h1);
    cycle(); wbEn = 1'b0; decValid = 1'b0;
    cycle();
    checkOutput("t3_valid", {31'b0, exValid}, 32'h1);
    checkOutput("t3_op1", exOp1, 32'hDEAD);
    checkOutput("t3_tag", exTag, 32'hD4);

    $display("[TB] writeback bypass during READ");
    applyStimulus(1'b1, 4'd4, 4'd5, 4'd5, 3'b111, 4'd7, 1'b1, 32'h0, 32'hE5); #1;
    checkOutput("byp_ready", {31'b0, decReady}, 32'h1);
    cycle(); decValid = 1'b0;
    wbEn = 1'b1; wbAddr = 4'd5; wbData = 32'hBEEF;
    cycle(); wbEn = 1'b0;
    checkOutput("byp_op1", exOp1, 32'hBEEF);
    checkOutput("byp_op2", exOp2, 32'hBEEF);
    checkOutput("byp_op3", exOp3, 32'h10);
    checkOutput("byp_tag", exTag, 32'hE5);

    $display("[TB] flush in READ");
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd7, 3'b001, 4'd0, 1'b0, 32'h0, 32'hF6); #1;
    checkOutput("t6_r7_hazard", {31'b0, decReady}, 32'h0);
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 32'h0, 32'hF6); #1;
    checkOutput("t6_ready", {31'b0, decReady}, 32'h1);
    cycle(); decValid = 1'b0; flush = 1'b1; #1;
    checkOutput("t6_flush_ready", {31'b0, decReady}, 32'h0);
    cycle(); flush = 1'b0;
    checkOutput("t6_flush_valid", {31'b0, exValid}, 32'h0);
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd7, 3'b001, 4'd9, 1'b1, 32'h0, 32'h77A); #1;
    checkOutput("t6_busy7_clear", {31'b0, decReady}, 32'h1);
    cycle(); decValid = 1'b0; exReady = 1'b0;
    cycle();
    checkOutput("t6_valid", {31'b0, exValid}, 32'h1);
    checkOutput("t6_op1", exOp1, 32'h77);

    $display("[TB] reset mid-HOLD");
    rst = 1'b0;
    cycle(); rst = 1'b1;
    checkOutput("t6_rst_valid", {31'b0, exValid}, 32'h0);
    checkOutput("t6_rst_op1", exOp1, 32'h0);
    checkOutput("t6_rst_tag", exTag, 32'h0);
    checkOutput("t6_rst_radd1", {28'b0, radd1}, 32'h0);
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd9, 3'b001, 4'd9, 1'b1, 32'h0, 32'h99A);
    wbEn = 1'b1; wbAddr = 4'd9; wbData = 32'h99; #1;
    checkOutput("t6_busy9_clear", {31'b0, decReady}, 32'h1);

    $display("[TB] set beats clear on same register");
    cycle(); wbEn = 1'b0; decValid = 1'b0;
    cycle();
    checkOutput("sw_op1", exOp1, 32'h99);
    exReady = 1'b1;
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd9, 3'b001, 4'd0, 1'b0, 32'h0, 32'hAB); #1;
    checkOutput("sw_hazard", {31'b0, decReady}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
